pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised N-lane pipeline stage register; successor to the fixed dual-issue ID/EX register.
- Carries per-lane valid, control and data payload plus a shared PC between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds explicit valid bits, hold (stall), bubble insertion, global flush and per-lane kill with a fixed priority.
- Supports optional saturating performance counters.

Parameters:
- LANES, 2, number of issue lanes (1..4).
- DATA_W, 32, payload width per lane in bits.
- CTRL_W, 12, control-bit width per lane.
- PC_W, 32, shared program-counter width.
- CLEAR_DATA, 1, 1 = flush/bubble zero data and PC; 0 = only valid and ctrl are cleared, data and PC keep their old value.
- CNT_W, 16, performance counter width (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  in  1  rising-edge clock.
- btnc_i  in  1  asynchronous active-high reset.
- flush_i  in  1  squash the whole stage (taken branch, PCSrc).
- stall_i  in  1  hold current contents (downstream not advancing).
- bubble_i  in  1  load a NOP (load-use hazard; upstream held).
- kill_i  in  LANES  per-lane squash of incoming lane (e.g. lane1 behind a taken lane0 branch).
- in_valid  in  LANES  incoming lane valid.
- in_ctrl  in  LANES*CTRL_W  lane k at bits [k*CTRL_W +: CTRL_W].
- in_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
- in_pc  in  PC_W  PC of the lane-0 instruction.
- out_valid  out  LANES  registered lane valid.
- out_ctrl  out  LANES*CTRL_W  registered control; always 0 for an invalid lane.
- out_data  out  LANES*DATA_W  registered payload.
- out_pc  out  PC_W  registered PC.
- out_any_valid  out  1  OR of out_valid, registered.

Behaviour:
- Reset: btnc_i high asynchronously clears all outputs to 0, independent of clk, and clears the counters. The first update occurs on the first rising edge after deassertion.
- Priority on each rising edge, highest first:
  - flush_i
  - stall_i
  - bubble_i
  - normal load
- flush_i=1: out_valid=0 and out_ctrl=0. If CLEAR_DATA=1, out_data=0 and out_pc=0; otherwise they hold.
- stall_i=1 (no flush): every register holds. kill_i, bubble_i and in_* are ignored.
- bubble_i=1 (no flush/stall): same clearing as flush. This is counted separately.
- Normal load, for each lane k:
  - out_valid[k] = in_valid[k] & ~kill_i[k].
  - out_ctrl lane k = in_ctrl lane k if the resulting valid is 1, else 0.
  - out_data lane k always loads in_data lane k.
- Normal load: out_pc loads in_pc if any lane is valid after kill. Otherwise it follows the CLEAR_DATA rule.
- Latency is exactly 1 cycle from input to output. There is no combinational path from any input to any output.
- out_any_valid is registered with the same priority as out_valid. It equals the OR of the next out_valid.
- Simultaneous flush and stall: flush wins, and the stage empties even while stalled.
- Simultaneous stall and bubble: stall wins, with no valid loss.
- Reset asserted mid-stall: contents clear immediately. After reset, the stage loads normally unless stall_i is still high, in which case it holds zeros.
- Lanes are independent. Killing lane 1 never affects lane 0, and killing lane 0 does not shift lane 1 (no compaction).

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt (each CNT_W bits, registered, reset to 0).
  - Each counter increments by 1 per edge where its event wins the priority.
  - Each counter saturates at all-ones and does not wrap.
  - Input perf_clr_i (1 bit, synchronous) zeroes all three counters and has priority over increment.
- Undefined: these ports and registers are absent, and behaviour is otherwise identical.

Test Plan (LANES=2, DATA_W=32, CTRL_W=12, CLEAR_DATA=1):
- Reset mid-cycle: assert btnc_i between edges with out_valid=2'b11 -> outputs 0 before the next edge; the first edge after release with in_valid=2'b11, in_data={32'hB,32'hA}, in_pc=32'h100 -> out_valid=2'b11, out_data={B,A}, out_pc=32'h100.
- Stall hold: load {B,A}, then stall_i=1 for 3 cycles with in_data={D,C} -> out stays {B,A}, out_valid=2'b11; release -> {D,C} on the next edge.
- Bubble: bubble_i=1 with in_valid=2'b11, in_ctrl=12'hFFF -> out_valid=0, out_ctrl=0, out_data=0, out_any_valid=0.
- Per-lane kill: in_valid=2'b11, kill_i=2'b10, in_ctrl={12'h123,12'h456} -> out_valid=2'b01, lane0 ctrl=12'h456, lane1 ctrl=0.
- Priority: flush_i=stall_i=bubble_i=1 -> stage empties (flush wins); stall_i=bubble_i=1 -> contents held.
- With PIPE_PERF_CNT_EN and CNT_W=4: 20 consecutive stall cycles -> perf_stall_cnt=4'hF (saturated); perf_clr_i pulse -> 0; flush_i=stall_i=1 for 1 edge -> perf_flush_cnt=1, perf_stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Bus bundle for pipe_stage_reg: hazard controls, lane payload in/out and,
// with PIPE_PERF_CNT_EN defined, the performance-counter clear and outputs.
interface pipe_stage_reg_if #(
   parameter int unsigned LANES  = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 12,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned CNT_W  = 16
);
   logic                     flush_i;
   logic                     stall_i;
   logic                     bubble_i;
   logic [LANES-1:0]         kill_i;
   logic [LANES-1:0]         in_valid;
   logic [LANES*CTRL_W-1:0]  in_ctrl;
   logic [LANES*DATA_W-1:0]  in_data;
   logic [PC_W-1:0]          in_pc;
   logic [LANES-1:0]         out_valid;
   logic [LANES*CTRL_W-1:0]  out_ctrl;
   logic [LANES*DATA_W-1:0]  out_data;
   logic [PC_W-1:0]          out_pc;
   logic                     out_any_valid;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_reg_if: CNT_W must be at least 1");
   end

`ifdef PIPE_PERF_CNT_EN
   logic                     perf_clr_i;
   logic [CNT_W-1:0]         perf_stall_cnt;
   logic [CNT_W-1:0]         perf_bubble_cnt;
   logic [CNT_W-1:0]         perf_flush_cnt;

   modport master (
      output flush_i, stall_i, bubble_i, kill_i, in_valid, in_ctrl, in_data, in_pc, perf_clr_i,
      input  out_valid, out_ctrl, out_data, out_pc, out_any_valid,
             perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt
   );
   modport slave (
      input  flush_i, stall_i, bubble_i, kill_i, in_valid, in_ctrl, in_data, in_pc, perf_clr_i,
      output out_valid, out_ctrl, out_data, out_pc, out_any_valid,
             perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt
   );
`else
   modport master (
      output flush_i, stall_i, bubble_i, kill_i, in_valid, in_ctrl, in_data, in_pc,
      input  out_valid, out_ctrl, out_data, out_pc, out_any_valid
   );
   modport slave (
      input  flush_i, stall_i, bubble_i, kill_i, in_valid, in_ctrl, in_data, in_pc,
      output out_valid, out_ctrl, out_data, out_pc, out_any_valid
   );
`endif
endinterface

// File: rtl/pipe_stage_reg.sv
// N-lane pipeline stage register with flush > stall > bubble > load priority and
// per-lane kill. Optional saturating event counters under PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
   parameter int unsigned LANES      = 2,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned CTRL_W     = 12,
   parameter int unsigned PC_W       = 32,
   parameter bit          CLEAR_DATA = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input logic             clk,
   input logic             btnc_i,
   pipe_stage_reg_if.slave bus
);
   localparam int unsigned CW = LANES * CTRL_W;
   localparam int unsigned DW = LANES * DATA_W;

   if (LANES < 1 || LANES > 4) begin : g_bad_lanes
      $error("pipe_stage_reg: LANES must be in 1..4");
   end

   logic [LANES-1:0] valid_q, valid_d;
   logic [CW-1:0]    ctrl_q,  ctrl_d;
   logic [DW-1:0]    data_q,  data_d;
   logic [PC_W-1:0]  pc_q,    pc_d;
   logic             any_q,   any_d;
   logic [LANES-1:0] lane_v;
   logic             clear_ev;

   // Bubble shares the flush clearing path but only when the stage is not stalled.
   always_comb begin
      valid_d  = valid_q;
      ctrl_d   = ctrl_q;
      data_d   = data_q;
      pc_d     = pc_q;
      lane_v   = bus.in_valid & ~bus.kill_i;
      clear_ev = bus.flush_i || (!bus.stall_i && bus.bubble_i);
      if (clear_ev) begin
         valid_d = '0;
         ctrl_d  = '0;
         if (CLEAR_DATA) begin
            data_d = '0;
            pc_d   = '0;
         end
      end else if (!bus.stall_i) begin
         valid_d = lane_v;
         data_d  = bus.in_data;
         for (int k = 0; k < int'(LANES); k++) begin
            ctrl_d[k*CTRL_W +: CTRL_W] = lane_v[k] ? bus.in_ctrl[k*CTRL_W +: CTRL_W] : CTRL_W'(0);
         end
         if (|lane_v) begin
            pc_d = bus.in_pc;
         end else if (CLEAR_DATA) begin
            pc_d = '0;
         end
      end
      any_d = |valid_d;
   end

   always_ff @(posedge clk or posedge btnc_i) begin
      if (btnc_i) begin
         valid_q <= '0;
         ctrl_q  <= '0;
         data_q  <= '0;
         pc_q    <= '0;
         any_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
         any_q   <= any_d;
      end
   end

   assign bus.out_valid     = valid_q;
   assign bus.out_ctrl      = ctrl_q;
   assign bus.out_data      = data_q;
   assign bus.out_pc        = pc_q;
   assign bus.out_any_valid = any_q;

`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;
   logic             stall_ev, bubble_ev;

   assign stall_ev  = bus.stall_i && !bus.flush_i;
   assign bubble_ev = bus.bubble_i && !bus.stall_i && !bus.flush_i;

   // Each counter tracks only the event that actually won the priority this edge.
   always_ff @(posedge clk or posedge btnc_i) begin
      if (btnc_i) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else if (bus.perf_clr_i) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         if (bus.flush_i && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         if (stall_ev && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (bubble_ev && bubble_cnt_q != CNT_MAX) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
   end

   assign bus.perf_stall_cnt  = stall_cnt_q;
   assign bus.perf_bubble_cnt = bubble_cnt_q;
   assign bus.perf_flush_cnt  = flush_cnt_q;
`else
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_reg: CNT_W must be at least 1");
   end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (2 lanes, CLEAR_DATA=1); counter checks run
// when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;
   localparam int unsigned LANES  = 2;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 12;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned CNT_W  = 4;

   logic clk;
   logic btnc_i;
   int   checks   = 0;
   int   failures = 0;

   pipe_stage_reg_if #(.LANES(LANES), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   pipe_stage_reg #(
      .LANES(LANES), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_W(PC_W),
      .CLEAR_DATA(1'b1), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .btnc_i(btnc_i),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [1:0] v, input logic [23:0] c,
                            input logic [63:0] d, input logic [31:0] pc);
      check({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
      check({tag, "_ctrl"},  64'(bus.out_ctrl),  64'(c));
      check({tag, "_data"},  64'(bus.out_data),  d);
      check({tag, "_pc"},    64'(bus.out_pc),    64'(pc));
      check({tag, "_any"},   64'(bus.out_any_valid), 64'(|v));
   endtask

   initial begin
      btnc_i       = 1'b1;
      bus.flush_i  = 1'b0;
      bus.stall_i  = 1'b0;
      bus.bubble_i = 1'b0;
      bus.kill_i   = 2'b00;
      bus.in_valid = 2'b00;
      bus.in_ctrl  = '0;
      bus.in_data  = '0;
      bus.in_pc    = '0;
`ifdef PIPE_PERF_CNT_EN
      bus.perf_clr_i = 1'b0;
`endif
      #12;
      check_out("reset", 2'b00, 24'h0, 64'h0, 32'h0);

      // first load after reset release
      bus.in_valid = 2'b11;
      bus.in_ctrl  = {12'h0AA, 12'h055};
      bus.in_data  = {32'hB, 32'hA};
      bus.in_pc    = 32'h100;
      btnc_i       = 1'b0;
      step();
      check_out("load1", 2'b11, 24'h0AA055, {32'hB, 32'hA}, 32'h100);

      // asynchronous reset between edges
      #2 btnc_i = 1'b1;
      #1 check_out("rst_async", 2'b00, 24'h0, 64'h0, 32'h0);
      #1 btnc_i = 1'b0;
      step();
      check_out("post_rst", 2'b11, 24'h0AA055, {32'hB, 32'hA}, 32'h100);

      // stall holds; in_*, kill and bubble ignored
      bus.stall_i  = 1'b1;
      bus.bubble_i = 1'b1;
      bus.kill_i   = 2'b01;
      bus.in_valid = 2'b00;
      bus.in_ctrl  = {12'h321, 12'h654};
      bus.in_data  = {32'hD, 32'hC};
      bus.in_pc    = 32'h200;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("stall", 2'b11, 24'h0AA055, {32'hB, 32'hA}, 32'h100);
      end
      bus.stall_i  = 1'b0;
      bus.bubble_i = 1'b0;
      bus.kill_i   = 2'b00;
      bus.in_valid = 2'b11;
      step();
      check_out("stall_rel", 2'b11, 24'h321654, {32'hD, 32'hC}, 32'h200);

      // bubble clears everything
      bus.bubble_i = 1'b1;
      bus.in_ctrl  = {12'hFFF, 12'hFFF};
      step();
      check_out("bubble", 2'b00, 24'h0, 64'h0, 32'h0);
      bus.bubble_i = 1'b0;

      // per-lane kill, no compaction
      bus.kill_i  = 2'b10;
      bus.in_ctrl = {12'h123, 12'h456};
      bus.in_data = {32'h22, 32'h11};
      bus.in_pc   = 32'h300;
      step();
      check_out("kill1", 2'b01, 24'h000456, {32'h22, 32'h11}, 32'h300);
      bus.kill_i = 2'b01;
      bus.in_pc  = 32'h304;
      step();
      check_out("kill0", 2'b10, 24'h123000, {32'h22, 32'h11}, 32'h304);
      bus.kill_i = 2'b11;
      bus.in_pc  = 32'h400;
      step();
      check_out("kill_all", 2'b00, 24'h0, {32'h22, 32'h11}, 32'h0);

      // flush beats stall and bubble
      bus.kill_i  = 2'b00;
      bus.in_ctrl = {12'h0AA, 12'h055};
      bus.in_data = {32'hB, 32'hA};
      bus.in_pc   = 32'h100;
      step();
      check_out("reload", 2'b11, 24'h0AA055, {32'hB, 32'hA}, 32'h100);
      bus.flush_i  = 1'b1;
      bus.stall_i  = 1'b1;
      bus.bubble_i = 1'b1;
      step();
      check_out("flush_all", 2'b00, 24'h0, 64'h0, 32'h0);

      // stall beats bubble
      bus.flush_i  = 1'b0;
      bus.stall_i  = 1'b0;
      bus.bubble_i = 1'b0;
      step();
      bus.stall_i  = 1'b1;
      bus.bubble_i = 1'b1;
      bus.in_data  = {32'hD, 32'hC};
      step();
      check_out("stall_bub", 2'b11, 24'h0AA055, {32'hB, 32'hA}, 32'h100);

      // reset during stall, then stall still high holds zeros
      #2 btnc_i = 1'b1;
      #1 check_out("rst_stall", 2'b00, 24'h0, 64'h0, 32'h0);
      #1 btnc_i = 1'b0;
      step();
      check_out("rst_stall_hold", 2'b00, 24'h0, 64'h0, 32'h0);
      bus.stall_i  = 1'b0;
      bus.bubble_i = 1'b0;
      step();
      check_out("rst_stall_rel", 2'b11, 24'h0AA055, {32'hD, 32'hC}, 32'h100);

`ifdef PIPE_PERF_CNT_EN
      bus.stall_i = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check("perf_stall_sat", 64'(bus.perf_stall_cnt), 64'hF);
      bus.stall_i    = 1'b0;
      bus.perf_clr_i = 1'b1;
      step();
      check("perf_clr", 64'(bus.perf_stall_cnt), 64'h0);
      bus.perf_clr_i = 1'b0;
      bus.flush_i    = 1'b1;
      bus.stall_i    = 1'b1;
      step();
      check("perf_flush", 64'(bus.perf_flush_cnt), 64'h1);
      check("perf_stall_nf", 64'(bus.perf_stall_cnt), 64'h0);
      bus.flush_i  = 1'b0;
      bus.stall_i  = 1'b0;
      bus.bubble_i = 1'b1;
      step();
      check("perf_bubble", 64'(bus.perf_bubble_cnt), 64'h1);
      check("perf_flush_hold", 64'(bus.perf_flush_cnt), 64'h1);
      bus.perf_clr_i = 1'b1;
      step();
      check("perf_clr_prio_b", 64'(bus.perf_bubble_cnt), 64'h0);
      check("perf_clr_prio_f", 64'(bus.perf_flush_cnt), 64'h0);
      bus.perf_clr_i = 1'b0;
      bus.bubble_i   = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
